// File: rtl/fp32_pkg.sv
// Purpose: shared constants, FSM state type and field-slice helpers for the fp32 multiplier slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [7:0] EXP_INF  = 8'hFF;
  localparam int         QNAN_BIT = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fp_mul_state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_man(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic f_is_nan(input logic [31:0] x);
    return (f_exp(x) == EXP_INF) && (f_man(x) != 23'd0);
  endfunction

  // Quiet the NaN payload: the top mantissa bit is forced on.
  function automatic logic [22:0] f_qnan_man(input logic [31:0] x);
    logic [22:0] m;
    m           = f_man(x);
    m[QNAN_BIT] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Purpose: final right-normalise, round and range-classify of the 48-bit significand product.
// Latency: combinational (sampled by the core in its last NORM cycle).
// Backpressure: none; pure function of its inputs.
// Ports: prod (product, already left-normalised), exp_in (signed working exponent),
//        e_out/m_out (raw exponent/mantissa for the fixup stage).
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even, otherwise truncation.
module fp_round_norm
  import fp32_pkg::*;
#(
  parameter int EXP_W = fp32_pkg::EXP_W,
  parameter int MAN_W = fp32_pkg::MAN_W
) (
  input  logic [2*MAN_W+1:0]       prod,
  input  logic signed [EXP_W+1:0]  exp_in,
  output logic [EXP_W-1:0]         e_out,
  output logic [MAN_W-1:0]         m_out
);

  localparam int SIG_W = MAN_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int XW    = EXP_W + 2;

  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic signed [XW-1:0] X_ZERO = XW'(0);
  localparam logic signed [XW-1:0] X_MAX  = XW'((1 << EXP_W) - 1);

`ifdef FP_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic [PW-2:0]          p;
  logic                   lost;
  logic signed [XW-1:0]   x;
  logic [SIG_W-1:0]       sig;
  logic                   guard;
  logic                   sticky;
  logic                   rnd;
  logic [SIG_W:0]         sum;
  logic [SIG_W-1:0]       sig_r;
  logic signed [XW-1:0]   xr;

  always_comb begin
    // An overflowing product (bit 47) is shifted right once; the bit
    // falling off still counts towards sticky.
    p     = prod[PW-1] ? prod[PW-1:1] : prod[PW-2:0];
    lost  = prod[PW-1] & prod[0];
    x     = prod[PW-1] ? exp_in + X_ONE : exp_in;

    sig    = p[PW-2 -: SIG_W];
    guard  = p[MAN_W-1];
    sticky = (|p[MAN_W-2:0]) | lost;
    rnd    = RNE & guard & (sticky | sig[0]);

    // A carry out of the rounded significand renormalises by one more place.
    sum   = {1'b0, sig} + {{SIG_W{1'b0}}, rnd};
    sig_r = sum[SIG_W] ? sum[SIG_W:1] : sum[SIG_W-1:0];
    xr    = sum[SIG_W] ? x + X_ONE : x;

    e_out = '0;
    m_out = '0;
    if (xr >= X_MAX) begin
      e_out = '1;
    end else if (xr > X_ZERO) begin
      // Hidden bit clear here only happens at exponent 1: a denormal.
      e_out = sig_r[SIG_W-1] ? xr[EXP_W-1:0] : '0;
      m_out = sig_r[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/fp32_mul_core.sv
// Purpose: sequential fp32 multiply producing raw sign/exponent/mantissa plus forwarded operands.
// Latency: 26 cycles accept-to-out_valid (+1 per extra left-normalise cycle); NaN operand: 1 cycle.
// Backpressure: one op in flight; in_ready low from accept until after the result handshake.
// Ports: in_valid/in_ready/a/b (operand handshake), out_valid/out_ready (result handshake),
//        a_o/b_o (registered operands), sign_o/e_o/m_o (raw product fields).
// Build option: FP_MUL_RNE_EN (see fp_round_norm) selects RNE rounding instead of truncation.
module fp32_mul_core
  import fp32_pkg::*;
#(
  parameter int EXP_W = fp32_pkg::EXP_W,
  parameter int MAN_W = fp32_pkg::MAN_W,
  parameter int BIAS  = fp32_pkg::BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      a_o,
  output logic [31:0]      b_o,
  output logic             sign_o,
  output logic [EXP_W-1:0] e_o,
  output logic [MAN_W-1:0] m_o
);

  localparam int SIG_W = MAN_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int XW    = EXP_W + 2;
  localparam int CW    = $clog2(SIG_W);

  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic        [XW-1:0] X_BIAS = XW'(BIAS);
  localparam logic        [CW-1:0] LAST   = CW'(SIG_W - 1);

  fp_mul_state_t        state;
  logic                 in_rdy_q;
  logic                 out_vld_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic                 sign_q;
  logic [EXP_W-1:0]     e_q;
  logic [MAN_W-1:0]     m_q;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        mcand;
  logic [SIG_W-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic signed [XW-1:0] xexp;

  logic [EXP_W-1:0]     rn_e;
  logic [MAN_W-1:0]     rn_m;

  // Denormal operands use hidden bit 0 and an effective exponent of 1.
  function automatic logic [SIG_W-1:0] sig_of(input logic [31:0] x);
    return {f_exp(x) != 8'd0, f_man(x)};
  endfunction

  function automatic logic [XW-1:0] xexp_of(input logic [31:0] x);
    return (f_exp(x) == 8'd0) ? XW'(1) : {2'b00, f_exp(x)};
  endfunction

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .prod   (acc),
    .exp_in (xexp),
    .e_out  (rn_e),
    .m_out  (rn_m)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      e_q       <= '0;
      m_q       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      xexp      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // in_ready comes up one edge after reset release.
          if (!in_rdy_q) begin
            in_rdy_q <= 1'b1;
          end else if (in_valid) begin
            in_rdy_q <= 1'b0;
            a_q      <= a;
            b_q      <= b;
            sign_q   <= f_sign(a) ^ f_sign(b);
            acc      <= '0;
            mcand    <= {{SIG_W{1'b0}}, sig_of(a)};
            mplier   <= sig_of(b);
            cnt      <= '0;
            xexp     <= xexp_of(a) + xexp_of(b) - X_BIAS;
            state    <= ST_MUL;
          end
        end

        ST_MUL: begin
          if (cnt == '0 && (f_is_nan(a_q) || f_is_nan(b_q))) begin
            e_q       <= '1;
            m_q       <= f_is_nan(a_q) ? f_qnan_man(a_q) : f_qnan_man(b_q);
            out_vld_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            // LSB-first shift-add: the multiplicand moves up one place per bit.
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= ST_NORM;
            end
          end
        end

        ST_NORM: begin
          if (acc[PW-1] || acc[PW-2] || xexp <= X_ONE) begin
            e_q   <= rn_e;
            m_q   <= rn_m;
            state <= ST_DONE;
          end else begin
            acc  <= acc << 1;
            xexp <= xexp - X_ONE;
          end
        end

        ST_DONE: begin
          // Result fields were registered on the way in; valid follows a cycle later.
          if (!out_vld_q) begin
            out_vld_q <= 1'b1;
          end else if (out_ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign sign_o    = sign_q;
  assign e_o       = e_q;
  assign m_o       = m_q;

endmodule

// File: tb/tb_fp32_mul_core.sv
// Purpose: scoreboard bench for fp32_mul_core with a behavioural fp32 product model.
// Latency: checks accept-to-out_valid cycle count for every result.
// Backpressure: drives out_ready always-high, random, or held low.
module tb_fp32_mul_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic        sign_o;
  logic [7:0]  e_o;
  logic [22:0] m_o;

`ifdef FP_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  always #5 clk = ~clk;

  fp32_mul_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_o       (a_o),
    .b_o       (b_o),
    .sign_o    (sign_o),
    .e_o       (e_o),
    .m_o       (m_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sbq[$];
  exp_t mexp;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic longint unsigned m_sig(input logic [31:0] x);
    return {40'd0, (x[30:23] != 8'd0), x[22:0]};
  endfunction

  function automatic int m_exp(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
  endfunction

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
    exp_t r;
    longint unsigned p, sig, rem, half;
    int x, k, sh;
    r.a = av; r.b = bv; r.s = av[31] ^ bv[31]; r.t0 = 0;
    if (m_nan(av) || m_nan(bv)) begin
      r.e   = 8'hFF;
      r.m   = (m_nan(av) ? av[22:0] : bv[22:0]) | 23'h400000;
      r.lat = 1;
      return r;
    end
    p  = m_sig(av) * m_sig(bv);
    x  = m_exp(av) + m_exp(bv) - 127;
    sh = 0;
    k  = 23;
    if (p >= (64'd1 << 47)) begin
      k = 24;
      x = x + 1;
    end else begin
      while (p < (64'd1 << 46) && x > 1) begin
        p  = p << 1;
        x  = x - 1;
        sh = sh + 1;
      end
    end
    sig  = p >> k;
    rem  = p & ((64'd1 << k) - 1);
    half = 64'd1 << (k - 1);
    if (RNE && (rem > half || (rem == half && sig[0]))) sig = sig + 1;
    if (sig >= (64'd1 << 24)) begin
      sig = sig >> 1;
      x   = x + 1;
    end
    if (x >= 255) begin
      r.e = 8'hFF; r.m = 23'd0;
    end else if (x <= 0) begin
      r.e = 8'd0;  r.m = 23'd0;
    end else if (sig < (64'd1 << 23)) begin
      r.e = 8'd0;  r.m = sig[22:0];
    end else begin
      r.e = 8'(x); r.m = sig[22:0];
    end
    r.lat = 26 + sh;
    return r;
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_vld = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] h_a, h_b;
  logic        h_s;
  logic [7:0]  h_e;
  logic [22:0] h_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_a_o", a_o, h_a);
        chk("hold_b_o", b_o, h_b);
        chk("hold_fields", {8'd0, sign_o, e_o, m_o}, {8'd0, h_s, h_e, h_m});
      end
      if (out_valid) chk("busy_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && !prev_vld) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got e=0x%0h m=0x%0h, expected no result", e_o, m_o);
        end else begin
          mexp = sbq.pop_front();
          chk("sign_o", 32'(sign_o), 32'(mexp.s));
          chk("e_o", 32'(e_o), 32'(mexp.e));
          chk("m_o", 32'(m_o), 32'(mexp.m));
          chk("a_o", a_o, mexp.a);
          chk("b_o", b_o, mexp.b);
          chk("latency", 32'(cyc - mexp.t0), 32'(mexp.lat));
        end
      end
      prev_vld   = out_valid;
      prev_stall = out_valid && !out_ready;
      h_a = a_o; h_b = b_o; h_s = sign_o; h_e = e_o; h_m = m_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input bit directed,
                      input logic [7:0] de, input logic [22:0] dm, input int dlat);
    exp_t x;
    int w;
    x = model(av, bv);
    if (directed) begin
      x.e = de; x.m = dm; x.lat = dlat;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 after %0d cycles, expected 1", w);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    x.t0 = cyc;
    sbq.push_back(x);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 || out_valid) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d results pending, expected 0", sbq.size());
        sbq.delete();
        return;
      end
    end
  endtask

  function automatic logic [31:0] rnd_op(input int lo, input int hi);
    logic [7:0] e;
    e = 8'($urandom_range(lo, hi));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    int kind;
    int w;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_o", a_o, 32'd0);
    chk("rst_b_o", b_o, 32'd0);
    chk("rst_fields", {8'd0, sign_o, e_o, m_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Directed test-plan cases
    rdy_mode = 0;
    send(32'h3FC00000, 32'h40000000, 1'b1, 8'd128, 23'h400000, 26);
    send(32'h40400000, 32'hC0400000, 1'b1, 8'd130, 23'h100000, 26);
    send(32'h7F000000, 32'h7F000000, 1'b1, 8'd255, 23'h000000, 26);
    send(32'h7F800001, 32'h3F800000, 1'b1, 8'd255, 23'h400001, 1);
    send(32'h3F800001, 32'h3FC00000, 1'b1, 8'd127, RNE ? 23'h400002 : 23'h400001, 26);
    drain();

    // Backpressure: hold out_ready low for 10 cycles once the result is up
    rdy_mode = 2;
    send(32'h3FC00000, 32'h40000000, 1'b1, 8'd128, 23'h400000, 26);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) @(posedge clk);
    rdy_mode = 0;
    drain();

    // Reset mid-MUL aborts the operation
    send(32'h40400000, 32'h40400000, 1'b0, 8'd0, 23'd0, 0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_rst_valid", 32'(out_valid), 32'd0);
      chk("abort_rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("abort_no_out", 32'(out_valid), 32'd0);
    end
    send(32'h40400000, 32'hC0400000, 1'b1, 8'd130, 23'h100000, 26);
    drain();

    // Randomised operands with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin ra = $urandom;        rb = $urandom;        end
        1: begin ra = rnd_op(64, 190); rb = rnd_op(64, 190); end
        2: begin ra = rnd_op(100, 150); rb = rnd_op(90, 160); end
        default: begin ra = rnd_op(0, 30); rb = rnd_op(80, 130); end
      endcase
      send(ra, rb, 1'b0, 8'd0, 23'd0, 0);
    end
    drain();
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
